window_monitor: RTL and testbench
=================================

Name: window_monitor

Overview:
Parametrised multi-channel window (range) monitor for the DSP datapath. It takes result samples from two producers, the filter engine and the transform engine, and optionally converts each sample to magnitude. Every channel checks the sample against its own programmable strict window (lo < d < hi). A channel raises a sticky active-low alarm only after PERSIST consecutive out-of-window samples, and keeps a saturating violation count. Alarm outputs drive board LEDs directly; a debounced clear button re-arms all channels.

Parameters:
DW, 16, sample and threshold width
NCH, 4, number of monitored channels
PERSIST, 3, consecutive violations needed to raise an alarm (>=1; 1 = immediate)
CNTW, 8, width of each per-channel violation counter
ABS_MODE, 1, 1 = two's-complement magnitude with unsigned compare; 0 = raw sample with signed compare

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_load  in  1  capture lo_thr/hi_thr into shadow registers at this edge
lo_thr  in  NCH*DW  lower bounds, channel i at [i*DW +: DW]
hi_thr  in  NCH*DW  upper bounds, same packing
src0_valid  in  1  filter-engine sample strobe
src0_data  in  DW  filter-engine sample
src1_valid  in  1  transform-engine sample strobe
src1_data  in  DW  transform-engine sample
clear_n  in  1  asynchronous push-button, low = clear
alarm_n  out  NCH  per-channel alarm, 0 = alarm (LED lit)
viol_cnt  out  NCH*CNTW  saturating violation counts
collision  out  1  sticky flag: both sources were valid in the same cycle
armed  out  1  at least one cfg_load has occurred since reset

Behaviour:
- Reset values: alarm_n all 1, viol_cnt 0, collision 0, armed 0, shadow lo = 0, shadow hi = 0, all channel FSMs in OK with run counter 0, clear synchroniser = 1.
- Sample select: src0 has priority. If both sources are valid, src0_data is used and collision is set. A sample is accepted in any cycle where src0_valid or src1_valid is high.
- Magnitude (ABS_MODE=1): if MSB is 1, d = ~x + 1, else d = x; the result is unsigned DW bits. The most negative input (0x8000) maps to 32768. For ABS_MODE=0, d = x and all compares are signed.
- Window test: in = (lo < d) && (d < hi), with strict bounds. If hi <= lo the window is empty, so every sample violates.
- Thresholds: the shadow registers update on edges where cfg_load = 1, and that same edge sets armed. A sample arriving in the same cycle as cfg_load is judged against the old shadows. While armed = 0, samples are ignored: no FSM or counter change, collision is still tracked.
- Per-channel FSM, evaluated on each accepted sample while armed:
  - OK: violation with PERSIST = 1 -> ALARM; violation otherwise -> PEND with run = 1; in-window -> stay OK.
  - PEND: violation with run+1 = PERSIST -> ALARM; violation otherwise -> run++; in-window -> OK with run = 0.
  - ALARM: sticky; only a clear leaves it.
- alarm_n[i] is registered and equals 0 exactly when the FSM is in ALARM. It falls on the same edge that accepts the PERSIST-th consecutive violation.
- viol_cnt[i] increments on every violating accepted sample, in any state, and saturates at 2^CNTW-1.
- Clear: clear_n passes through a 2-flop synchroniser, so the synchronised low is visible in the cycle after the 2nd edge. While it is low, every channel goes to OK, run = 0, viol_cnt = 0, alarm_n = 1 and collision = 0. Clear has priority over a same-cycle sample, which is dropped. Shadow thresholds and armed are preserved.
- Asserting reset mid-operation returns everything to reset values immediately.

Decomposition:
- Shared package/header holds the FSM state encodings (OK = 2'd0, PEND = 2'd1, ALARM = 2'd2), the default parameter constants and the magnitude function.
- Sub-module window_monitor_ch holds one channel: window compare, FSM, run counter and saturating counter. It is instantiated NCH times in a generate loop.
- The top level holds source select, magnitude, shadow registers, clear synchroniser and collision flag.

Test Plan:
1. Reset, no cfg_load; drive src0 samples 0, 500, 0xFFFF -> alarm_n = 4'b1111, all viol_cnt = 0, armed = 0.
2. cfg_load with ch0 = (100,200) and ch1 = (0,1000); src0 samples 150, 250, 250, 250 -> alarm_n[0] falls on the edge of the 3rd 250, viol_cnt0 = 3; ch1 stays high with viol_cnt1 = 0.
3. Same window, samples 250, 250, 150, 250, 250 -> no alarm, viol_cnt0 = 4. Then 200 (boundary) -> alarm, viol_cnt0 = 5.
4. ABS_MODE = 1, ch0 = (100,300): samples 0xFF38 (-200) -> in-window; 0x8000 x3 -> magnitude 32768, alarm raised.
5. Drive clear_n low for 1 cycle with an alarm active, plus src0_valid during the clear -> alarm_n and counts reset by the 3rd edge after the fall; the concurrent sample is not counted; shadows retained.
6. src0 = 150 and src1 = 999 valid together with cfg_load changing ch0 hi to 120 -> 150 is judged against the old window (in), collision = 1; the next 150 violates under the new window.

Source files
------------

// File: rtl/window_monitor_pkg.sv
// Shared types and helpers for the multi-channel window monitor.
// Channel FSM encoding, default parameters and the magnitude function.
package window_monitor_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_NCH      = 4;
  localparam int DEF_PERSIST  = 3;
  localparam int DEF_CNTW     = 8;
  localparam int DEF_ABS_MODE = 1;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALARM = 2'd2
  } ch_state_e;

  // Two's-complement magnitude of a w-bit value held in the low bits.
  // The most negative input maps to 2^(w-1), which still fits unsigned.
  function automatic logic [63:0] magnitude(
    input logic [63:0] x,
    input int unsigned w
  );
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (x[w-1])
      return (~x + 64'd1) & mask;
    else
      return x & mask;
  endfunction

endpackage

// File: rtl/window_monitor_ch.sv
// One monitored channel: strict window compare, persistence FSM,
// consecutive-violation run counter and saturating violation counter.
module window_monitor_ch
  import window_monitor_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int PERSIST    = DEF_PERSIST,
  parameter int CNTW       = DEF_CNTW,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   d,
  input  logic [DW-1:0]   lo,
  input  logic [DW-1:0]   hi,
  output logic            alarm_n,
  output logic [CNTW-1:0] viol_cnt
);

  localparam int RW = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);
  localparam logic [RW-1:0]   P_RW    = RW'(PERSIST);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  ch_state_e       state_q, state_d;
  logic [RW-1:0]   run_q, run_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            alarm_n_q;
  logic            in_win;
  logic            viol;

  // Empty windows (hi <= lo) fall out naturally: no d satisfies both.
  generate
    if (SIGNED_CMP) begin : g_scmp
      assign in_win = ($signed(lo) < $signed(d)) &&
                      ($signed(d) < $signed(hi));
    end else begin : g_ucmp
      assign in_win = (lo < d) && (d < hi);
    end
  endgenerate

  assign viol = ~in_win;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ST_OK;
      run_d   = '0;
      cnt_d   = '0;
    end else if (en) begin
      if (viol && cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNTW'(1);
      unique case (state_q)
        ST_OK: begin
          if (viol) begin
            if (PERSIST == 1) begin
              state_d = ST_ALARM;
            end else begin
              state_d = ST_PEND;
              run_d   = RW'(1);
            end
          end
        end
        ST_PEND: begin
          if (viol) begin
            if (run_q + RW'(1) == P_RW)
              state_d = ST_ALARM;
            else
              run_d = run_q + RW'(1);
          end else begin
            state_d = ST_OK;
            run_d   = '0;
          end
        end
        ST_ALARM: begin
          state_d = ST_ALARM;
        end
        default: begin
          state_d = ST_OK;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_OK;
      run_q     <= '0;
      cnt_q     <= '0;
      alarm_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      alarm_n_q <= (state_d != ST_ALARM);
    end
  end

  assign alarm_n  = alarm_n_q;
  assign viol_cnt = cnt_q;

endmodule

// File: rtl/window_monitor.sv
// Multi-channel window monitor top: source select, magnitude,
// threshold shadows, clear synchroniser and collision flag.
module window_monitor
  import window_monitor_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NCH      = DEF_NCH,
  parameter int PERSIST  = DEF_PERSIST,
  parameter int CNTW     = DEF_CNTW,
  parameter int ABS_MODE = DEF_ABS_MODE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_load,
  input  logic [NCH*DW-1:0]   lo_thr,
  input  logic [NCH*DW-1:0]   hi_thr,
  input  logic                src0_valid,
  input  logic [DW-1:0]       src0_data,
  input  logic                src1_valid,
  input  logic [DW-1:0]       src1_data,
  input  logic                clear_n,
  output logic [NCH-1:0]      alarm_n,
  output logic [NCH*CNTW-1:0] viol_cnt,
  output logic                collision,
  output logic                armed
);

  logic [NCH*DW-1:0] lo_q, hi_q;
  logic              armed_q;
  logic              coll_q;
  logic [1:0]        clr_sync;
  logic              clr;
  logic              accept;
  logic [DW-1:0]     sel_d;
  logic [DW-1:0]     cmp_d;

  assign accept = src0_valid | src1_valid;
  assign sel_d  = src0_valid ? src0_data : src1_data;

  generate
    if (ABS_MODE != 0) begin : g_abs
      assign cmp_d = DW'(magnitude(64'(sel_d), DW));
    end else begin : g_raw
      assign cmp_d = sel_d;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      clr_sync <= 2'b11;
    else
      clr_sync <= {clr_sync[0], clear_n};
  end

  assign clr = ~clr_sync[1];

  // Clear leaves the thresholds and armed state untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q    <= '0;
      hi_q    <= '0;
      armed_q <= 1'b0;
    end else if (cfg_load) begin
      lo_q    <= lo_thr;
      hi_q    <= hi_thr;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      coll_q <= 1'b0;
    else if (clr)
      coll_q <= 1'b0;
    else if (src0_valid && src1_valid)
      coll_q <= 1'b1;
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      window_monitor_ch #(
        .DW        (DW),
        .PERSIST   (PERSIST),
        .CNTW      (CNTW),
        .SIGNED_CMP(ABS_MODE == 0)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .en      (accept & armed_q),
        .d       (cmp_d),
        .lo      (lo_q[i*DW +: DW]),
        .hi      (hi_q[i*DW +: DW]),
        .alarm_n (alarm_n[i]),
        .viol_cnt(viol_cnt[i*CNTW +: CNTW])
      );
    end
  endgenerate

  assign collision = coll_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_window_monitor.sv
// Self-checking bench for window_monitor: directed scenarios plus a
// randomized run compared every cycle against a behavioural model.
module tb_window_monitor;

  localparam int DW       = 16;
  localparam int NCH      = 4;
  localparam int PERSIST  = 3;
  localparam int CNTW     = 8;
  localparam int ABS_MODE = 1;
  localparam int CMAX     = (1 << CNTW) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_load;
  logic [NCH*DW-1:0]   lo_thr, hi_thr;
  logic                src0_valid, src1_valid;
  logic [DW-1:0]       src0_data, src1_data;
  logic                clear_n;
  logic [NCH-1:0]      alarm_n;
  logic [NCH*CNTW-1:0] viol_cnt;
  logic                collision, armed;

  int checks = 0;
  int errors = 0;

  int          m_cons [NCH];
  bit          m_alarm[NCH];
  int          m_cnt  [NCH];
  logic [DW-1:0] m_lo [NCH];
  logic [DW-1:0] m_hi [NCH];
  bit          m_coll, m_armed;
  bit          h_old, h_new;

  window_monitor #(
    .DW(DW), .NCH(NCH), .PERSIST(PERSIST),
    .CNTW(CNTW), .ABS_MODE(ABS_MODE)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .lo_thr(lo_thr), .hi_thr(hi_thr),
    .src0_valid(src0_valid), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_data(src1_data),
    .clear_n(clear_n), .alarm_n(alarm_n), .viol_cnt(viol_cnt),
    .collision(collision), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic bit in_window(input int i, input logic [DW-1:0] x);
    longint d, lo, hi;
    if (ABS_MODE != 0) begin
      d  = x[DW-1] ? ((longint'(1) << DW) - longint'(x)) : longint'(x);
      lo = longint'(m_lo[i]);
      hi = longint'(m_hi[i]);
    end else begin
      d  = longint'($signed(x));
      lo = longint'($signed(m_lo[i]));
      hi = longint'($signed(m_hi[i]));
    end
    return (lo < d) && (d < hi);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cons[i] = 0; m_alarm[i] = 0; m_cnt[i] = 0;
      m_lo[i] = '0;  m_hi[i] = '0;
    end
    m_coll = 0; m_armed = 0; h_old = 1; h_new = 1;
  endtask

  // Model state transition for one rising edge, from the inputs held there.
  task automatic model_edge();
    bit clr;
    logic [DW-1:0] x;
    if (reset) begin
      model_reset();
      return;
    end
    clr   = !h_old;
    h_old = h_new;
    h_new = clear_n;
    x = src0_valid ? src0_data : src1_data;
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        m_cons[i] = 0; m_alarm[i] = 0; m_cnt[i] = 0;
      end
      m_coll = 0;
    end else begin
      if (src0_valid && src1_valid) m_coll = 1;
      if (m_armed && (src0_valid || src1_valid)) begin
        for (int i = 0; i < NCH; i++) begin
          if (!in_window(i, x)) begin
            if (m_cnt[i] < CMAX) m_cnt[i]++;
            m_cons[i]++;
            if (m_cons[i] >= PERSIST) m_alarm[i] = 1;
          end else begin
            m_cons[i] = 0;
          end
        end
      end
    end
    if (cfg_load) begin
      m_armed = 1;
      for (int i = 0; i < NCH; i++) begin
        m_lo[i] = lo_thr[i*DW +: DW];
        m_hi[i] = hi_thr[i*DW +: DW];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("alarm_n[%0d]", i), alarm_n[i], !m_alarm[i]);
      chk($sformatf("viol_cnt[%0d]", i),
          viol_cnt[i*CNTW +: CNTW], m_cnt[i]);
    end
    chk("collision", collision, m_coll);
    chk("armed", armed, m_armed);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cfg_load = 0; src0_valid = 0; src1_valid = 0;
  endtask

  task automatic s0(input logic [DW-1:0] v);
    idle(); src0_valid = 1; src0_data = v; step(); idle();
  endtask

  task automatic set_win(input int ch, input logic [DW-1:0] lo,
                         input logic [DW-1:0] hi);
    lo_thr[ch*DW +: DW] = lo;
    hi_thr[ch*DW +: DW] = hi;
  endtask

  task automatic do_clear();
    idle(); clear_n = 0; step(); clear_n = 1; step(); step(); step();
  endtask

  function automatic int cnt0();
    return int'(viol_cnt[0 +: CNTW]);
  endfunction

  initial begin
    reset = 1; clear_n = 1; idle();
    src0_data = '0; src1_data = '0; lo_thr = '0; hi_thr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    compare_all();

    // 1: unarmed samples are ignored
    s0(16'd0); s0(16'd500); s0(16'hFFFF);
    chk("t1 alarm_n", alarm_n, 4'b1111);
    chk("t1 cnt0", cnt0(), 0);
    chk("t1 armed", armed, 0);

    // 2: persistence of three
    set_win(0, 16'd100, 16'd200);
    set_win(1, 16'd0, 16'd1000);
    cfg_load = 1; step(); idle();
    s0(16'd150); s0(16'd250); s0(16'd250);
    chk("t2 pre alarm0", alarm_n[0], 1);
    s0(16'd250);
    chk("t2 alarm0", alarm_n[0], 0);
    chk("t2 cnt0", cnt0(), 3);
    chk("t2 alarm1", alarm_n[1], 1);
    chk("t2 cnt1", viol_cnt[CNTW +: CNTW], 0);

    // 3: interrupted run, then upper boundary violates
    do_clear();
    s0(16'd250); s0(16'd250); s0(16'd150); s0(16'd250); s0(16'd250);
    chk("t3 no alarm", alarm_n[0], 1);
    chk("t3 cnt0", cnt0(), 4);
    s0(16'd200);
    chk("t3 alarm", alarm_n[0], 0);
    chk("t3 cnt0b", cnt0(), 5);

    // 4: magnitude
    set_win(0, 16'd100, 16'd300);
    cfg_load = 1; step(); idle();
    do_clear();
    s0(16'hFF38);
    chk("t4 in", cnt0(), 0);
    s0(16'h8000); s0(16'h8000); s0(16'h8000);
    chk("t4 alarm", alarm_n[0], 0);
    chk("t4 cnt0", cnt0(), 3);

    // 5: clear with concurrent sample
    idle(); clear_n = 0; step();
    clear_n = 1; step();
    src0_valid = 1; src0_data = 16'h8000; step(); idle();
    chk("t5 alarm cleared", alarm_n[0], 1);
    chk("t5 cnt0", cnt0(), 0);
    s0(16'h8000); s0(16'h8000); s0(16'h8000);
    chk("t5 shadow kept", alarm_n[0], 0);

    // 6: collision and same-edge cfg_load
    do_clear();
    set_win(0, 16'd100, 16'd120);
    src0_valid = 1; src0_data = 16'd150;
    src1_valid = 1; src1_data = 16'd999;
    cfg_load = 1; step(); idle();
    chk("t6 old window", cnt0(), 0);
    chk("t6 collision", collision, 1);
    s0(16'd150);
    chk("t6 new window", cnt0(), 1);

    // mid-operation asynchronous reset
    idle(); src0_valid = 1; src0_data = 16'd5;
    @(negedge clk); reset = 1; #1;
    chk("async armed", armed, 0);
    chk("async collision", collision, 0);
    model_reset();
    step(); reset = 0; idle();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      idle();
      clear_n = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_load = 1;
        for (int i = 0; i < NCH; i++)
          set_win(i, DW'($urandom_range(0, 60)),
                  DW'($urandom_range(0, 130)));
      end
      src0_valid = ($urandom_range(0, 2) != 0);
      src1_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        src0_data = DW'($urandom());
        src1_data = DW'($urandom());
      end else begin
        src0_data = DW'($urandom_range(0, 140) - 70 + 40);
        src1_data = DW'($urandom_range(0, 140));
      end
      reset = ($urandom_range(0, 599) == 0);
      step();
      reset = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
